// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA stream output block: FSM states, default
// 800x480 timing and the colour-bar table used by the optional test pattern.
package vga_pkg;

    typedef enum logic [1:0] {
        StSync,
        StRun,
        StRecover
    } vga_state_e;

    localparam int unsigned DefHDisp  = 800;
    localparam int unsigned DefVDisp  = 480;
    localparam int unsigned DefHFp    = 40;
    localparam int unsigned DefHPulse = 48;
    localparam int unsigned DefHBp    = 40;
    localparam int unsigned DefVFp    = 13;
    localparam int unsigned DefVPulse = 3;
    localparam int unsigned DefVBp    = 29;
    localparam int unsigned DefRgbW   = 24;
    localparam int unsigned NumBars   = 8;

    // Classic 8-bar pattern, left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] rgb;
        unique case (idx)
            3'd0: rgb = 24'hFFFFFF;
            3'd1: rgb = 24'hFFFF00;
            3'd2: rgb = 24'h00FFFF;
            3'd3: rgb = 24'h00FF00;
            3'd4: rgb = 24'hFF00FF;
            3'd5: rgb = 24'hFF0000;
            3'd6: rgb = 24'h0000FF;
            default: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running raster counters with display-area and sync-pulse decode.
// Flags are active-high and unregistered; polarity and pipelining are applied by the caller.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned HDISP  = DefHDisp,
    parameter int unsigned VDISP  = DefVDisp,
    parameter int unsigned HFP    = DefHFp,
    parameter int unsigned HPULSE = DefHPulse,
    parameter int unsigned HBP    = DefHBp,
    parameter int unsigned VFP    = DefVFp,
    parameter int unsigned VPULSE = DefVPulse,
    parameter int unsigned VBP    = DefVBp,
    parameter int unsigned HCntW  = $clog2(HDISP + HFP + HPULSE + HBP),
    parameter int unsigned VCntW  = $clog2(VDISP + VFP + VPULSE + VBP)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [HCntW-1:0] hcnt_o,
    output logic [VCntW-1:0] vcnt_o,
    output logic             de_o,
    output logic             hs_o,
    output logic             vs_o
);

    localparam int unsigned HTotal = HDISP + HFP + HPULSE + HBP;
    localparam int unsigned VTotal = VDISP + VFP + VPULSE + VBP;

    logic [HCntW-1:0] hcnt_q, hcnt_d;
    logic [VCntW-1:0] vcnt_q, vcnt_d;

    always_comb begin
        hcnt_d = hcnt_q + HCntW'(1);
        vcnt_d = vcnt_q;
        if (32'(hcnt_q) == HTotal - 1) begin
            hcnt_d = '0;
            vcnt_d = (32'(vcnt_q) == VTotal - 1) ? '0 : vcnt_q + VCntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt_o = hcnt_q;
    assign vcnt_o = vcnt_q;
    assign de_o   = (32'(hcnt_q) < HDISP) && (32'(vcnt_q) < VDISP);
    assign hs_o   = (32'(hcnt_q) >= HDISP + HFP) && (32'(hcnt_q) < HDISP + HFP + HPULSE);
    assign vs_o   = (32'(vcnt_q) >= VDISP + VFP) && (32'(vcnt_q) < VDISP + VFP + VPULSE);

endmodule

// File: rtl/vga_stream_out.sv
// Pixel stream to VGA raster: locks the stream to the raster on SOF, flags underruns and
// misalignment. Define VGA_STREAM_TESTPAT_EN to add the testpat_en colour-bar override.
module vga_stream_out
    import vga_pkg::*;
#(
    parameter int unsigned HDISP  = DefHDisp,
    parameter int unsigned VDISP  = DefVDisp,
    parameter int unsigned HFP    = DefHFp,
    parameter int unsigned HPULSE = DefHPulse,
    parameter int unsigned HBP    = DefHBp,
    parameter int unsigned VFP    = DefVFp,
    parameter int unsigned VPULSE = DefVPulse,
    parameter int unsigned VBP    = DefVBp,
    parameter int unsigned RGB_W  = DefRgbW,
    parameter bit          HS_POL = 1'b0,
    parameter bit          VS_POL = 1'b0
) (
    input  logic             pixel_clk,
    input  logic             pixel_rst_n,
    input  logic             s_valid,
    input  logic [RGB_W-1:0] s_data,
    input  logic             s_sof,
    output logic             s_ready,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_blank,
    output logic [RGB_W-1:0] vga_rgb,
    input  logic             err_clr,
    output logic             err_sticky,
    output logic [15:0]      err_cnt,
`ifdef VGA_STREAM_TESTPAT_EN
    input  logic             testpat_en,
`endif
    output logic             in_sync
);

    localparam int unsigned HCntW = $clog2(HDISP + HFP + HPULSE + HBP);
    localparam int unsigned VCntW = $clog2(VDISP + VFP + VPULSE + VBP);

    logic [HCntW-1:0] hcnt;
    logic [VCntW-1:0] vcnt;
    logic             de, hs_act, vs_act;

    vga_timing #(
        .HDISP (HDISP),
        .VDISP (VDISP),
        .HFP   (HFP),
        .HPULSE(HPULSE),
        .HBP   (HBP),
        .VFP   (VFP),
        .VPULSE(VPULSE),
        .VBP   (VBP),
        .HCntW (HCntW),
        .VCntW (VCntW)
    ) u_timing (
        .clk_i (pixel_clk),
        .rst_ni(pixel_rst_n),
        .hcnt_o(hcnt),
        .vcnt_o(vcnt),
        .de_o  (de),
        .hs_o  (hs_act),
        .vs_o  (vs_act)
    );

    vga_state_e       state_q, state_d;
    logic             ready, err_evt, origin, last_de;
    logic [RGB_W-1:0] rgb_d, rgb_q;
    logic             hs_q, vs_q, blank_q, sticky_q;
    logic [15:0]      err_cnt_q;

    assign origin  = (hcnt == '0) && (vcnt == '0);
    assign last_de = (32'(hcnt) == HDISP - 1) && (32'(vcnt) == VDISP - 1);

`ifdef VGA_STREAM_TESTPAT_EN
    localparam int unsigned BarW = (HDISP / NumBars > 0) ? HDISP / NumBars : 1;
    logic [RGB_W-1:0] bar_rgb;
    assign bar_rgb = RGB_W'(bar_colour(3'(32'(hcnt) / BarW)));
`endif

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        rgb_d   = '0;
        err_evt = 1'b0;
        unique case (state_q)
            StSync: begin
                // Only the SOF beat is held back; everything else is flushed until (0,0).
                ready = !s_sof || origin;
                if (s_valid && s_sof && origin) begin
                    rgb_d   = s_data;
                    state_d = StRun;
                end
            end
            StRun: begin
                ready = de;
                if (de) begin
                    if (!s_valid) begin
                        err_evt = 1'b1;
                        state_d = StRecover;
                    end else begin
                        rgb_d = s_data;
                        if (s_sof && !origin) begin
                            err_evt = 1'b1;
                            state_d = StSync;
                        end
                    end
                end
            end
            StRecover: begin
                if (last_de) begin
                    state_d = StSync;
                end
            end
            default: state_d = StSync;
        endcase
`ifdef VGA_STREAM_TESTPAT_EN
        if (testpat_en) begin
            state_d = StSync;
            ready   = 1'b1;
            err_evt = 1'b0;
            rgb_d   = de ? bar_rgb : '0;
        end
`endif
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            state_q   <= StSync;
            hs_q      <= !HS_POL;
            vs_q      <= !VS_POL;
            blank_q   <= 1'b0;
            rgb_q     <= '0;
            sticky_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            hs_q    <= hs_act ? HS_POL : !HS_POL;
            vs_q    <= vs_act ? VS_POL : !VS_POL;
            blank_q <= de;
            rgb_q   <= rgb_d;
            if (err_clr) begin
                sticky_q  <= err_evt;
                err_cnt_q <= err_evt ? 16'd1 : 16'd0;
            end else if (err_evt) begin
                sticky_q <= 1'b1;
                if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_q <= err_cnt_q + 16'd1;
                end
            end
        end
    end

    // Reset holds the counters at (0,0), where SYNC would otherwise accept a beat.
    assign s_ready    = ready && pixel_rst_n;
    assign vga_hs     = hs_q;
    assign vga_vs     = vs_q;
    assign vga_blank  = blank_q;
    assign vga_rgb    = rgb_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = err_cnt_q;
    assign in_sync    = (state_q == StRun);

endmodule

// File: tb/tb_vga_stream_out.sv
// Bench for vga_stream_out on a reduced 16x6 raster (23x10 total) with active-high HS.
module tb_vga_stream_out;

    localparam int unsigned HD = 16, VD = 6, HF = 2, HP = 3, HB = 2, VF = 1, VP = 2, VB = 1;
    localparam int unsigned HT = HD + HF + HP + HB;
    localparam int unsigned VT = VD + VF + VP + VB;
    localparam int unsigned FR = HT * VT;
    localparam int unsigned W = 24;
    localparam bit HSP = 1'b1;
    localparam bit VSP = 1'b0;

    logic         pixel_clk = 1'b0;
    logic         pixel_rst_n = 1'b0;
    logic         s_valid = 1'b0;
    logic [W-1:0] s_data = '0;
    logic         s_sof = 1'b0;
    logic         s_ready, vga_hs, vga_vs, vga_blank, err_sticky, in_sync;
    logic [W-1:0] vga_rgb;
    logic         err_clr = 1'b0;
    logic [15:0]  err_cnt;

    always #5 pixel_clk = ~pixel_clk;

    vga_stream_out #(
        .HDISP(HD), .VDISP(VD), .HFP(HF), .HPULSE(HP), .HBP(HB),
        .VFP(VF), .VPULSE(VP), .VBP(VB), .RGB_W(W), .HS_POL(HSP), .VS_POL(VSP)
    ) dut (
        .pixel_clk  (pixel_clk),
        .pixel_rst_n(pixel_rst_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .s_ready    (s_ready),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_blank  (vga_blank),
        .vga_rgb    (vga_rgb),
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .in_sync    (in_sync)
    );

    int total = 0;
    int bad = 0;

    // Model: cycles since reset release give the raster position directly.
    int           cyc;
    int           mst;  // 0 = waiting for SOF, 1 = locked, 2 = recovering
    int           m_cnt;
    bit           m_sticky;
    bit           e_hs, e_vs, e_blank;
    logic [W-1:0] e_rgb;

    // Upstream source: frame f pixel k carries {f+1, k}; optional junk beats come first.
    logic [W-1:0] b_data;
    bit           b_sof;
    int           junk, sf, sk;

    bit rst_v = 1'b0;
    bit drop_req, inj_req, clr_now, clr_at_inj;
    int trig_h, trig_v;
    int win_lo = 0, win_hi = 0, n_hs = 0, n_vs = 0, n_bl = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic load_beat();
        if (junk > 0) begin
            b_data = 24'hEE0000 | 24'(junk);
            b_sof  = 1'b0;
            junk--;
        end else begin
            b_data = {8'(sf + 1), 16'(sk)};
            b_sof  = (sk == 0);
            sk++;
            if (sk == HD * VD) begin
                sk = 0;
                sf++;
            end
        end
    endtask

    task automatic model_reset();
        cyc = 0; mst = 0; m_cnt = 0; m_sticky = 1'b0;
        e_hs = !HSP; e_vs = !VSP; e_blank = 1'b0; e_rgb = '0;
    endtask

    task automatic compare_pins(input string t);
        chk({t, "_hs"}, 32'(vga_hs), 32'(e_hs));
        chk({t, "_vs"}, 32'(vga_vs), 32'(e_vs));
        chk({t, "_blank"}, 32'(vga_blank), 32'(e_blank));
        chk({t, "_rgb"}, 32'(vga_rgb), 32'(e_rgb));
        chk({t, "_in_sync"}, 32'(in_sync), 32'(mst == 1));
        chk({t, "_err_cnt"}, 32'(err_cnt), 32'(m_cnt));
        chk({t, "_sticky"}, 32'(err_sticky), 32'(m_sticky));
    endtask

    task automatic step_model();
        int h, v, nst;
        bit de, org, last, rdy, err;
        logic [W-1:0] nrgb;
        if (!pixel_rst_n) begin
            model_reset();
            compare_pins("rst");
            chk("rst_s_ready", 32'(s_ready), 32'(0));
            return;
        end
        compare_pins("run");
        if (cyc >= win_lo && cyc < win_hi) begin
            n_hs += (vga_hs == HSP) ? 1 : 0;
            n_vs += (vga_vs == VSP) ? 1 : 0;
            n_bl += vga_blank ? 1 : 0;
        end
        h = cyc % HT;
        v = (cyc / HT) % VT;
        de = (h < HD) && (v < VD);
        org = (h == 0) && (v == 0);
        last = (h == HD - 1) && (v == VD - 1);
        rdy = (mst == 0) ? (!s_sof || org) : (mst == 1) ? de : 1'b0;
        chk("s_ready", 32'(s_ready), 32'(rdy));
        nrgb = '0; err = 1'b0; nst = mst;
        if (mst == 0) begin
            if (s_valid && s_sof && org) begin nrgb = s_data; nst = 1; end
        end else if (mst == 1) begin
            if (de && !s_valid) begin
                err = 1'b1; nst = 2;
            end else if (de) begin
                nrgb = s_data;
                if (s_sof && !org) begin err = 1'b1; nst = 0; end
            end
        end else if (last) begin
            nst = 0;
        end
        if (err_clr) begin
            m_cnt = err ? 1 : 0; m_sticky = err;
        end else if (err) begin
            m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1; m_sticky = 1'b1;
        end
        mst = nst;
        e_hs = (h >= HD + HF && h < HD + HF + HP) ? HSP : !HSP;
        e_vs = (v >= VD + VF && v < VD + VF + VP) ? VSP : !VSP;
        e_blank = de;
        e_rgb = nrgb;
        if (s_valid && rdy) load_beat();
        cyc++;
    endtask

    task automatic cycle();
        int h, v;
        bit was_up;
        @(posedge pixel_clk);
        #1;
        h = cyc % HT;
        v = (cyc / HT) % VT;
        was_up = pixel_rst_n;
        pixel_rst_n = rst_v;
        s_valid = 1'b1;
        s_data = b_data;
        s_sof = b_sof;
        err_clr = clr_now;
        clr_now = 1'b0;
        if (drop_req && h == trig_h && v == trig_v) begin s_valid = 1'b0; drop_req = 1'b0; end
        if (inj_req && h == trig_h && v == trig_v) begin
            s_sof = 1'b1; inj_req = 1'b0;
            if (clr_at_inj) err_clr = 1'b1;
        end
        if (was_up && !rst_v) begin
            #1;
            chk("async_rst_hs", 32'(vga_hs), 32'(0));
            chk("async_rst_vs", 32'(vga_vs), 32'(1));
            chk("async_rst_blank", 32'(vga_blank), 32'(0));
            chk("async_rst_rgb", 32'(vga_rgb), 32'(0));
            chk("async_rst_ready", 32'(s_ready), 32'(0));
            chk("async_rst_err", 32'(err_cnt), 32'(0));
        end
        @(negedge pixel_clk);
        step_model();
    endtask

    // Returns with the pins showing the output for raster position p (cycle p since release).
    task automatic run_to(input int p);
        while (cyc < p + 2) cycle();
    endtask

    initial begin
        sf = 0; sk = 0; junk = 0;
        drop_req = 0; inj_req = 0; clr_now = 0; clr_at_inj = 0;
        load_beat();
        model_reset();
        rst_v = 1'b0;
        repeat (3) cycle();
        rst_v = 1'b1;

        run_to(0);
        chk("first_rgb", 32'(vga_rgb), 32'h010000);
        chk("first_in_sync", 32'(in_sync), 32'(1));
        run_to(HT + 3);
        chk("rgb_l1_p3", 32'(vga_rgb), 32'h010013);

        win_lo = FR + 2; win_hi = 2 * FR + 2;
        run_to(2 * FR);
        chk("hs_per_frame", 32'(n_hs), 32'(30));
        chk("vs_per_frame", 32'(n_vs), 32'(46));
        chk("de_per_frame", 32'(n_bl), 32'(96));
        chk("frame2_rgb", 32'(vga_rgb), 32'h030000);

        drop_req = 1; trig_v = 2; trig_h = 5;
        run_to(2 * FR + 2 * HT + 5);
        chk("underrun_rgb", 32'(vga_rgb), 32'h000000);
        chk("underrun_blank", 32'(vga_blank), 32'(1));
        chk("underrun_err", 32'(err_cnt), 32'(1));
        chk("underrun_in_sync", 32'(in_sync), 32'(0));
        run_to(3 * FR);
        chk("relock1_rgb", 32'(vga_rgb), 32'h040000);
        chk("relock1_in_sync", 32'(in_sync), 32'(1));

        inj_req = 1; trig_v = 3; trig_h = 7;
        run_to(3 * FR + 3 * HT + 7);
        chk("misalign_rgb", 32'(vga_rgb), 32'h040037);
        chk("misalign_err", 32'(err_cnt), 32'(2));
        chk("misalign_in_sync", 32'(in_sync), 32'(0));
        run_to(4 * FR);
        chk("relock2_rgb", 32'(vga_rgb), 32'h050000);
        chk("relock2_sticky", 32'(err_sticky), 32'(1));
        clr_now = 1;
        cycle();
        cycle();
        chk("clr_err", 32'(err_cnt), 32'(0));
        chk("clr_sticky", 32'(err_sticky), 32'(0));

        inj_req = 1; clr_at_inj = 1; trig_v = 1; trig_h = 4;
        run_to(5 * FR + HT + 4);
        chk("clr_and_err_cnt", 32'(err_cnt), 32'(1));
        chk("clr_and_err_sticky", 32'(err_sticky), 32'(1));
        clr_at_inj = 0;
        run_to(6 * FR);
        chk("relock3_rgb", 32'(vga_rgb), 32'h070000);

        run_to(6 * FR + 50);
        rst_v = 1'b0;
        repeat (3) cycle();
        junk = 5; sf = 10; sk = 0;
        load_beat();
        rst_v = 1'b1;
        run_to(0);
        chk("post_rst_rgb", 32'(vga_rgb), 32'h000000);
        chk("post_rst_blank", 32'(vga_blank), 32'(1));
        chk("post_rst_in_sync", 32'(in_sync), 32'(0));
        run_to(HD + HF);
        chk("post_rst_hs", 32'(vga_hs), 32'(1));
        run_to((VD + VF) * HT);
        chk("post_rst_vs", 32'(vga_vs), 32'(0));
        run_to(FR);
        chk("junk_sof_rgb", 32'(vga_rgb), 32'h0B0000);
        chk("junk_in_sync", 32'(in_sync), 32'(1));
        chk("junk_err", 32'(err_cnt), 32'(0));
        run_to(2 * FR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
